l1_i_controller: RTL and testbench

Control FSM for the L1 instruction cache. It owns the tag and valid store and sequences `L1_I_data_array` through its `index`, `offset`, `refill` and `update` inputs. It accepts fetch requests from the core, decides hit or miss, runs the line-refill handshake with L2, and signals the core when `read_data_L1_C` from the data array is valid. It sits between the core fetch port, `L1_I_data_array` and the L2 request port.

---
 rtl/l1_i_pkg.sv | 21 ++
 rtl/l1_i_tag_array.sv | 47 ++++
 rtl/l1_i_controller.sv | 133 +++++++++++++
 tb/tb_l1_i_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_i_pkg.sv
// Shared types and default geometry for the L1 instruction-cache controller.
// Optional performance counters are enabled with `L1_I_PERF_CNT_EN.
package l1_i_pkg;

    localparam int unsigned DEF_ADDR_W   = 32;
    localparam int unsigned DEF_INDEX_W  = 6;
    localparam int unsigned DEF_OFFSET_W = 6;
    localparam int unsigned DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;

    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned INDEX_LSB  = DEF_OFFSET_W;
    localparam int unsigned TAG_LSB    = DEF_OFFSET_W + DEF_INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_MISS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/l1_i_tag_array.sv
// Tag and valid storage for the L1 instruction cache: combinational read,
// single write port for refills, bulk invalidate for flush.
module l1_i_tag_array #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 20
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic [INDEX_W-1:0] index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               clr_all
);

    localparam int unsigned SETS = 1 << INDEX_W;

    logic [SETS-1:0]  valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [SETS];
    logic [TAG_W-1:0] tag_d [SETS];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[index] = 1'b1;
            tag_d[index]   = wr_tag;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Tags are meaningless while their valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];

endmodule

// File: rtl/l1_i_controller.sv
// L1 instruction-cache control FSM: hit/miss decision, L2 line refill, core handshake.
// Define `L1_I_PERF_CNT_EN to add saturating hit_cnt / miss_cnt outputs.
module l1_i_controller
    import l1_i_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned INDEX_W  = DEF_INDEX_W,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                read_C_L1,
    input  logic [ADDR_W-1:0]   address,
    input  logic                flush,
    output logic                stall_L1_C,
    output logic                ready_L1_C,
    output logic                read_L1_L2,
    output logic [ADDR_W-1:0]   addr_L1_L2,
    input  logic                ready_L2_L1,
    output logic [INDEX_W-1:0]  index,
    output logic [OFFSET_W-1:0] offset,
    output logic                refill,
    output logic                update
`ifdef L1_I_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [TAG_W-1:0]    req_tag, rd_tag;
    logic                rd_valid, hit, clr_all;

    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
    assign index   = req_addr_q[OFFSET_W +: INDEX_W];
    assign offset  = req_addr_q[OFFSET_W-1:0];
    assign hit     = rd_valid && (rd_tag == req_tag);
    assign clr_all = (state_q == ST_IDLE) && flush;

    l1_i_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .nrst     (nrst),
        .index    (index),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (refill),
        .wr_tag   (req_tag),
        .clr_all  (clr_all)
    );

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!flush && read_C_L1) begin
                    req_addr_d = address;
                    state_d    = ST_COMPARE;
                end
            end
            ST_COMPARE: state_d = hit ? ST_RESP : ST_MISS;
            ST_MISS:    if (ready_L2_L1) state_d = ST_COMPARE;
            ST_RESP: begin
                if (read_C_L1) begin
                    req_addr_d = address;
                    state_d    = ST_COMPARE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Outputs decode straight from the state flop; refill is the only combinational path.
    assign stall_L1_C = (state_q == ST_COMPARE) || (state_q == ST_MISS);
    assign ready_L1_C = (state_q == ST_RESP);
    assign read_L1_L2 = (state_q == ST_MISS);
    assign refill     = (state_q == ST_MISS) && ready_L2_L1;
    assign addr_L1_L2 = {req_addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign update     = 1'b0;

`ifdef L1_I_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        refilled_q, refilled_d;

    // refilled_q marks the post-refill re-compare so it is not counted as a hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        refilled_d = refilled_q;
        if (refill) refilled_d = 1'b1;
        if (state_q == ST_COMPARE) begin
            refilled_d = 1'b0;
            if (hit && !refilled_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
            if (!hit && miss_cnt_q != '1)              miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            refilled_q <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            refilled_q <= refilled_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_i_controller.sv
// Self-checking bench for l1_i_controller: directed cache scenarios plus a
// randomized fetch/flush stream checked against a set-indexed reference cache.
module tb_l1_i_controller;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        read_C_L1 = 1'b0;
    logic [31:0] address = '0;
    logic        flush = 1'b0;
    logic        stall_L1_C, ready_L1_C, read_L1_L2, refill, update;
    logic [31:0] addr_L1_L2;
    logic        ready_L2_L1 = 1'b0;
    logic [5:0]  index, offset;
`ifdef L1_I_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference cache: one valid bit and tag per set, plus event counts.
    bit [63:0]   m_valid;
    bit [19:0]   m_tag [64];
    int unsigned m_hits, m_misses;

    always #5 clk = ~clk;

    l1_i_controller dut (
        .clk         (clk),
        .nrst        (nrst),
        .read_C_L1   (read_C_L1),
        .address     (address),
        .flush       (flush),
        .stall_L1_C  (stall_L1_C),
        .ready_L1_C  (ready_L1_C),
        .read_L1_L2  (read_L1_L2),
        .addr_L1_L2  (addr_L1_L2),
        .ready_L2_L1 (ready_L2_L1),
        .index       (index),
        .offset      (offset),
        .refill      (refill),
        .update      (update)
`ifdef L1_I_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    task automatic model_reset();
        m_valid  = '0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        ready_L2_L1 = 1'b1;
        read_C_L1 = 1'b1;
        address = 32'hFFFF_FFFF;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (stall_L1_C !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %b exp 0", stall_L1_C); end
        n_checks++; if (ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", ready_L1_C); end
        n_checks++; if (read_L1_L2 !== 1'b0) begin n_fail++; $display("FAIL rst_read_l2 got %b exp 0", read_L1_L2); end
        n_checks++; if (refill !== 1'b0) begin n_fail++; $display("FAIL rst_refill got %b exp 0", refill); end
        n_checks++; if (update !== 1'b0) begin n_fail++; $display("FAIL rst_update got %b exp 0", update); end
        n_checks++; if (addr_L1_L2 !== 32'h0) begin n_fail++; $display("FAIL rst_addr_l2 got %h exp 0", addr_L1_L2); end
        n_checks++; if (index !== 6'd0) begin n_fail++; $display("FAIL rst_index got %h exp 0", index); end
        n_checks++; if (offset !== 6'd0) begin n_fail++; $display("FAIL rst_offset got %h exp 0", offset); end
        ready_L2_L1 = 1'b0;
        read_C_L1 = 1'b0;
        address = '0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
    endtask

    task automatic idle_cycle();
        read_C_L1 = 1'b0;
        flush = 1'b0;
        ready_L2_L1 = 1'($urandom);
        @(negedge clk);
        #1;
        n_checks++; if (stall_L1_C !== 1'b0 || ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL idle_state stall %b ready %b exp 0 0", stall_L1_C, ready_L1_C); end
        n_checks++; if (refill !== 1'b0 || read_L1_L2 !== 1'b0) begin n_fail++; $display("FAIL idle_l2 refill %b read %b exp 0 0", refill, read_L1_L2); end
        ready_L2_L1 = 1'b0;
    endtask

    // Issues one fetch from IDLE or RESP and follows it to its RESP cycle.
    // With b2b set, the caller stays in RESP so the next fetch issues there.
    task automatic fetch(input logic [31:0] a, input int unsigned l2_delay, input bit b2b);
        logic [5:0]  idx;
        logic [19:0] tg;
        bit          exp_hit;
        idx = a[11:6];
        tg  = a[31:12];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        n_checks++; if (stall_L1_C !== 1'b0) begin n_fail++; $display("FAIL issue_stall got %b exp 0", stall_L1_C); end
        read_C_L1 = 1'b1;
        address = a;
        flush = 1'b0;
        ready_L2_L1 = 1'b0;
        @(negedge clk);
        read_C_L1 = 1'($urandom);
        address = $urandom;
        flush = 1'($urandom);
        ready_L2_L1 = 1'($urandom);
        #1;
        n_checks++; if (stall_L1_C !== 1'b1 || ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL cmp_state addr %h stall %b ready %b exp 1 0", a, stall_L1_C, ready_L1_C); end
        n_checks++; if (index !== idx || offset !== a[5:0]) begin n_fail++; $display("FAIL cmp_idx_off got %h/%h exp %h/%h", index, offset, idx, a[5:0]); end
        n_checks++; if (refill !== 1'b0 || read_L1_L2 !== 1'b0) begin n_fail++; $display("FAIL cmp_l2 refill %b read %b exp 0 0", refill, read_L1_L2); end
        @(negedge clk);
        if (!exp_hit) begin
            m_misses++;
            for (int unsigned c = 0; c <= l2_delay; c++) begin
                ready_L2_L1 = (c == l2_delay);
                read_C_L1 = 1'($urandom);
                flush = 1'($urandom);
                #1;
                n_checks++; if (read_L1_L2 !== 1'b1 || stall_L1_C !== 1'b1 || ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL miss_state addr %h read_l2 %b stall %b ready %b exp 1 1 0", a, read_L1_L2, stall_L1_C, ready_L1_C); end
                n_checks++; if (addr_L1_L2 !== {a[31:6], 6'b0}) begin n_fail++; $display("FAIL miss_addr got %h exp %h", addr_L1_L2, {a[31:6], 6'b0}); end
                n_checks++; if (refill !== (c == l2_delay)) begin n_fail++; $display("FAIL miss_refill cycle %0d got %b exp %b", c, refill, (c == l2_delay)); end
                @(negedge clk);
            end
            ready_L2_L1 = 1'($urandom);
            read_C_L1 = 1'($urandom);
            flush = 1'($urandom);
            #1;
            n_checks++; if (stall_L1_C !== 1'b1 || ready_L1_C !== 1'b0 || read_L1_L2 !== 1'b0 || refill !== 1'b0) begin n_fail++; $display("FAIL recmp_state stall %b ready %b read_l2 %b refill %b exp 1 0 0 0", stall_L1_C, ready_L1_C, read_L1_L2, refill); end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            @(negedge clk);
        end else begin
            m_hits++;
        end
        read_C_L1 = 1'b0;
        flush = 1'b0;
        ready_L2_L1 = 1'b0;
        #1;
        n_checks++; if (ready_L1_C !== 1'b1 || stall_L1_C !== 1'b0) begin n_fail++; $display("FAIL resp_ready addr %h ready %b stall %b exp 1 0", a, ready_L1_C, stall_L1_C); end
        n_checks++; if (read_L1_L2 !== 1'b0 || index !== idx || offset !== a[5:0]) begin n_fail++; $display("FAIL resp_fields read_l2 %b idx %h off %h exp 0 %h %h", read_L1_L2, index, offset, idx, a[5:0]); end
        if (!b2b) idle_cycle();
    endtask

    task automatic do_flush(input bit with_read);
        flush = 1'b1;
        read_C_L1 = with_read;
        address = $urandom;
        @(negedge clk);
        flush = 1'b0;
        read_C_L1 = 1'b0;
        #1;
        n_checks++; if (stall_L1_C !== 1'b0 || ready_L1_C !== 1'b0) begin n_fail++; $display("FAIL flush_idle stall %b ready %b exp 0 0", stall_L1_C, ready_L1_C); end
        m_valid = '0;
    endtask

    task automatic check_counters();
`ifdef L1_I_PERF_CNT_EN
        n_checks++; if (hit_cnt !== m_hits) begin n_fail++; $display("FAIL hit_cnt got %0d exp %0d", hit_cnt, m_hits); end
        n_checks++; if (miss_cnt !== m_misses) begin n_fail++; $display("FAIL miss_cnt got %0d exp %0d", miss_cnt, m_misses); end
`endif
    endtask

    task automatic test_directed();
        fetch(32'h0000_1040, 5, 1'b0);
        fetch(32'h0000_1044, 0, 1'b0);
        fetch(32'h0000_2040, 1, 1'b0);
        fetch(32'h0000_1040, 2, 1'b1);
        fetch(32'h0000_1044, 0, 1'b0);
        do_flush(1'b0);
        fetch(32'h0000_1044, 3, 1'b0);
        check_counters();
    endtask

    task automatic test_reset_mid_miss();
        logic [31:0] a;
        a = 32'h0000_3080;
        read_C_L1 = 1'b1;
        address = a;
        @(negedge clk);
        read_C_L1 = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (read_L1_L2 !== 1'b1) begin n_fail++; $display("FAIL rmm_pre_read got %b exp 1", read_L1_L2); end
        nrst = 1'b0;
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++; if (read_L1_L2 !== 1'b0 || refill !== 1'b0 || stall_L1_C !== 1'b0) begin n_fail++; $display("FAIL rmm_async read_l2 %b refill %b stall %b exp 0 0 0", read_L1_L2, refill, stall_L1_C); end
        n_checks++; if (addr_L1_L2 !== 32'h0 || index !== 6'd0) begin n_fail++; $display("FAIL rmm_addr got %h/%h exp 0/0", addr_L1_L2, index); end
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (refill !== 1'b0 || read_L1_L2 !== 1'b0 || stall_L1_C !== 1'b0) begin n_fail++; $display("FAIL rmm_late_ack refill %b read_l2 %b stall %b exp 0 0 0", refill, read_L1_L2, stall_L1_C); end
        ready_L2_L1 = 1'b0;
        check_counters();
        fetch(a, 1, 1'b0);
    endtask

    task automatic test_flush_priority();
        fetch(32'h0000_5100, 0, 1'b0);
        fetch(32'h0000_5104, 0, 1'b0);
        do_flush(1'b1);
        idle_cycle();
        fetch(32'h0000_5104, 2, 1'b0);
    endtask

    task automatic test_random();
        bit prev_b2b;
        logic [5:0] idx_pool [4];
        idx_pool = '{6'd0, 6'd1, 6'd2, 6'd63};
        prev_b2b = 1'b0;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            bit b2b;
            a = {20'($urandom_range(0, 2)), idx_pool[$urandom_range(0, 3)], 6'($urandom)};
            b2b = 1'($urandom);
            if (!prev_b2b && $urandom_range(0, 9) == 0) do_flush(1'($urandom));
            fetch(a, $urandom_range(0, 3), b2b);
            prev_b2b = b2b;
        end
        if (prev_b2b) idle_cycle();
        check_counters();
    endtask

    initial begin
        test_reset();
        idle_cycle();
        test_directed();
        test_reset_mid_miss();
        test_flush_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
